square_scan_ctrl: RTL and testbench
===================================

# square_scan_ctrl

Sequencer that walks the 64-square board memory and presents each engine-colour piece, one at a time, to the directional transmitter (`piece_reg`/`pos_reg`). It sits between board RAM and the transmitter/ray-propagation fabric. For each piece it holds the transmitter inputs stable for a settle window, then handshakes with the downstream move collector. Empty squares and opponent squares are skipped, so the fabric only ever sees engine-colour pieces.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the transmitter inputs are held before `emit_valid`; legal range 1..15.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a scan; sampled only in IDLE.
- `abort` in 1: synchronous cancel of a running scan.
- `engine_color` in 1: side to move, 1 = white, 0 = black; latched on accepted `start`.
- `rd_en` out 1: board RAM read strobe.
- `rd_addr` out 6: board RAM square address, 0..63.
- `rd_data` in 6: RAM piece code `{color, type[4:0]}`, valid one cycle after `rd_en`.
- `piece_reg` out 6: to transmitter; 6'b0 whenever no piece is presented.
- `pos_reg` out 6: to transmitter; square of the presented piece.
- `emit_valid` out 1: transmitter outputs are settled and the collector may capture them.
- `emit_ready` in 1: collector accepts; transfer occurs when `emit_valid` and `emit_ready` are both high.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a scan completes normally.
- `piece_count` out 7: number of pieces emitted in the current or last scan.

## Operation
- States: IDLE, FETCH, DECODE, SETTLE, EMIT, DONE.
- IDLE:
  - On `start`: latch `engine_color`, set `sq`=0, clear `piece_count`, go to FETCH.
  - `start` outside IDLE is ignored.
- FETCH: `rd_en`=1, `rd_addr`=`sq`, go to DECODE.
- DECODE evaluates `rd_data`:
  - Own piece (`type`!=0 and `rd_data[5]`==latched colour): load `piece_reg`=`rd_data`, `pos_reg`=`sq`, load settle counter with `SETTLE_CYCLES`-1, go to SETTLE.
  - Otherwise: advance.
- SETTLE: decrement the counter each cycle; at 0, go to EMIT.
- EMIT:
  - Hold `emit_valid`=1 with `piece_reg`/`pos_reg` stable until `emit_ready`.
  - On handshake: `piece_count`+1, clear `piece_reg` to 0, advance.
- Advance: if `sq`==63 go to DONE, else `sq`+1 and go to FETCH. `sq` never wraps.
- DONE: `done`=1 for one cycle, then IDLE. `piece_count` holds until the next accepted `start`.
- `abort`:
  - From any non-IDLE state, go to IDLE on the next edge.
  - Clear `piece_reg`, `pos_reg`, `emit_valid`, `rd_en`. No `done` pulse. `piece_count` keeps its partial value.
  - `abort` beats a simultaneous `emit_ready`: no count increment.
- Type codes:
  - pawn 00010, knight 00001, bishop 01000, rook 10000, queen 11000, king 00100, empty 00000.
  - The controller checks only nonzero type and colour. It does not validate one-hotness.

## Timing
- Reset values:
  - State IDLE.
  - `rd_en`, `emit_valid`, `busy`, `done` = 0.
  - `rd_addr`, `piece_reg`, `pos_reg` = 0.
  - `piece_count` = 0; latched colour = 0.
- `reset` overrides `abort` and `start`.
- RAM read latency is exactly 1 cycle; `rd_data` is sampled only in DECODE.
- A skipped square costs 2 cycles.
- An emitted piece costs 2 + `SETTLE_CYCLES` + (cycles waiting for `emit_ready`, minimum 1).
- Empty-board scan: with `start` in cycle 0, square 63 DECODE falls in cycle 128 and `done` is high in cycle 129. `busy` is high in cycles 1..129.
- `piece_reg`/`pos_reg` change only on DECODE-load, EMIT handshake, abort or reset. They are constant throughout SETTLE and EMIT.
- `emit_valid` never drops without a handshake, except on abort or reset.

## Structure
- Shared package `chess_pkg`:
  - Piece type codes, colour constants (WHITE=1, BLACK=0), `EMPTY`.
  - Square width (6) and the state enum.
  - The transmitter and move collector use the same package.
- One natural sub-module, `settle_timer`: a loadable down-counter with a `zero` flag, sized by `SETTLE_CYCLES`.
- The scan FSM, square counter and piece counter stay in the top module.

## Test plan
- Empty board (all 0), `start`: no `emit_valid`; `done` in cycle 129; `piece_count`=0; `rd_addr` visits 0..63 in order.
- Standard opening, `engine_color`=1 with white on squares 0..15, `emit_ready` tied high:
  - 16 emits, `pos_reg` 0..15 in order; `piece_count`=16.
  - First emit: `piece_reg`=6'b110000 (white rook), `pos_reg`=0.
- Same board, `engine_color`=0: emits only squares 48..63; white squares are never presented; `piece_count`=16.
- Black knight 6'b000001 on square 20, `engine_color`=0, `emit_ready` low for 5 cycles: `emit_valid` and `piece_reg`/`pos_reg` held stable for all 5 cycles, one handshake, `piece_count`=1.
- `abort` asserted in EMIT together with `emit_ready`: next cycle IDLE, `piece_reg`=0, `piece_count` unchanged, no `done`. A new `start` rescans from square 0.
- `reset` mid-SETTLE, and `start` while `busy`: after reset, all outputs at reset values. `start` while `busy` has no effect on `sq` or `piece_count`.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess definitions: piece type codes, colours, square width and
// the scan sequencer state encoding.
package chess_pkg;

   localparam int SQ_W = 6;

   localparam logic       WHITE = 1'b1;
   localparam logic       BLACK = 1'b0;
   localparam logic [5:0] EMPTY = 6'b000000;

   localparam logic [4:0] T_NONE   = 5'b00000;
   localparam logic [4:0] T_KNIGHT = 5'b00001;
   localparam logic [4:0] T_PAWN   = 5'b00010;
   localparam logic [4:0] T_KING   = 5'b00100;
   localparam logic [4:0] T_BISHOP = 5'b01000;
   localparam logic [4:0] T_ROOK   = 5'b10000;
   localparam logic [4:0] T_QUEEN  = 5'b11000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_SETTLE,
      ST_EMIT,
      ST_DONE
   } scan_state_t;

   // A square holds one of our pieces when its type is nonzero and the colour
   // bit matches the side to move; one-hotness of the type is not enforced.
   function automatic logic is_own_piece(input logic [5:0] code, input logic color);
      return (code[4:0] != T_NONE) && (code[5] == color);
   endfunction

endpackage

// File: rtl/square_scan_ctrl_settle_timer.sv
// Loadable down-counter that times the transmitter settle window.
module settle_timer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load takes priority, decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/square_scan_ctrl.sv
// Board scan sequencer: walks squares 0..63, presents each engine-colour
// piece to the transmitter, waits out the settle window, then hands the
// piece to the move collector with a valid/ready transfer.
module square_scan_ctrl
   import chess_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       engine_color,
   output logic       rd_en,
   output logic [5:0] rd_addr,
   input  logic [5:0] rd_data,
   output logic [5:0] piece_reg,
   output logic [5:0] pos_reg,
   output logic       emit_valid,
   input  logic       emit_ready,
   output logic       busy,
   output logic       done,
   output logic [6:0] piece_count
);

   scan_state_t state_q;
   logic        color_q;
   logic [5:0]  sq_q;
   logic        rd_en_q;
   logic [5:0]  rd_addr_q;
   logic [5:0]  piece_q;
   logic [5:0]  pos_q;
   logic        emit_valid_q;
   logic        busy_q;
   logic        done_q;
   logic [6:0]  count_q;

   logic [5:0]  sq_inc_d;
   logic        last_sq_d;
   logic        own_d;
   logic        timer_load_d;
   logic        timer_dec_d;
   logic        timer_zero;

   // Square bookkeeping and settle-timer controls derived from current state.
   always_comb begin
      sq_inc_d     = sq_q + 6'd1;
      last_sq_d    = (sq_q == 6'd63);
      own_d        = is_own_piece(rd_data, color_q);
      timer_load_d = (state_q == ST_DECODE) && own_d;
      timer_dec_d  = (state_q == ST_SETTLE);
   end

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk    (clk),
      .reset  (reset),
      .load_i (timer_load_d),
      .dec_i  (timer_dec_d),
      .zero_o (timer_zero)
   );

   // Scan FSM with registered outputs; abort wins over any handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         color_q      <= 1'b0;
         sq_q         <= 6'd0;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= 6'd0;
         piece_q      <= EMPTY;
         pos_q        <= 6'd0;
         emit_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         count_q      <= 7'd0;
      end else if (abort && (state_q != ST_IDLE)) begin
         state_q      <= ST_IDLE;
         rd_en_q      <= 1'b0;
         piece_q      <= EMPTY;
         pos_q        <= 6'd0;
         emit_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  color_q   <= engine_color;
                  sq_q      <= 6'd0;
                  count_q   <= 7'd0;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= 6'd0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               rd_en_q <= 1'b0;
               state_q <= ST_DECODE;
            end
            ST_DECODE: begin
               if (own_d) begin
                  piece_q <= rd_data;
                  pos_q   <= sq_q;
                  state_q <= ST_SETTLE;
               end else if (last_sq_d) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  sq_q      <= sq_inc_d;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= sq_inc_d;
                  state_q   <= ST_FETCH;
               end
            end
            ST_SETTLE: begin
               if (timer_zero) begin
                  emit_valid_q <= 1'b1;
                  state_q      <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (emit_ready) begin
                  count_q      <= count_q + 7'd1;
                  piece_q      <= EMPTY;
                  emit_valid_q <= 1'b0;
                  if (last_sq_d) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     sq_q      <= sq_inc_d;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= sq_inc_d;
                     state_q   <= ST_FETCH;
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rd_en       = rd_en_q;
   assign rd_addr     = rd_addr_q;
   assign piece_reg   = piece_q;
   assign pos_reg     = pos_q;
   assign emit_valid  = emit_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign piece_count = count_q;

endmodule

// File: tb/tb_square_scan_ctrl.sv
// Directed bench for square_scan_ctrl with a one-cycle-latency board RAM.
module tb_square_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, abort, engine_color, emit_ready;
   logic       rd_en, emit_valid, busy, done;
   logic [5:0] rd_addr, rd_data, piece_reg, pos_reg;
   logic [6:0] piece_count;
   logic [5:0] board [64];

   int checks = 0;
   int failures = 0;

   square_scan_ctrl #(.SETTLE_CYCLES(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .engine_color (engine_color),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .piece_reg    (piece_reg),
      .pos_reg      (pos_reg),
      .emit_valid   (emit_valid),
      .emit_ready   (emit_ready),
      .busy         (busy),
      .done         (done),
      .piece_count  (piece_count)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= board[rd_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic load_board(input int id);
      logic [4:0] back [8];
      back = '{5'b10000, 5'b00001, 5'b01000, 5'b11000, 5'b00100, 5'b01000, 5'b00001, 5'b10000};
      for (int i = 0; i < 64; i++) board[i] = 6'b0;
      case (id)
         1: begin
            for (int i = 0; i < 8; i++) begin
               board[i]      = {1'b1, back[i]};
               board[8 + i]  = 6'b100010;
               board[48 + i] = 6'b000010;
               board[56 + i] = {1'b0, back[i]};
            end
         end
         2: board[20] = 6'b000001;
         3: begin
            board[5]  = 6'b100010;
            board[10] = 6'b011000;
            board[30] = 6'b100000;
            board[63] = 6'b100001;
         end
         4: begin
            board[3] = 6'b000010;
            board[7] = 6'b000010;
         end
         default: ;
      endcase
   endtask

   // which: 0 = emit_valid, 1 = done, 2 = piece_reg nonzero
   task automatic wait_sig(input int which, input int limit, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < limit; c++) begin
         if ((which == 0 && emit_valid) || (which == 1 && done) ||
             (which == 2 && piece_reg != 6'b0)) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_scan(input logic c, output int n, output int fp, output int fpos,
                           output int lpos, output int dcyc, output bit addr_ok,
                           output bit emit_ok, output bit busy_ok);
      int exp_addr;
      exp_addr = 0; n = 0; fp = -1; fpos = -1; lpos = -1; dcyc = -1;
      addr_ok = 1'b1; emit_ok = 1'b1; busy_ok = 1'b1;
      emit_ready = 1'b1;
      @(negedge clk); start = 1'b1; engine_color = c;
      @(negedge clk); start = 1'b0;
      for (int cyc = 1; cyc < 2000; cyc++) begin
         if (rd_en) begin
            if (exp_addr > 63 || rd_addr != exp_addr[5:0]) addr_ok = 1'b0;
            exp_addr++;
         end
         if (emit_valid) begin
            if (n == 0) begin
               fp = int'(piece_reg); fpos = int'(pos_reg);
            end else if (int'(pos_reg) <= lpos) begin
               emit_ok = 1'b0;
            end
            if (piece_reg[4:0] == 5'b0 || piece_reg[5] != c) emit_ok = 1'b0;
            lpos = int'(pos_reg);
            n++;
         end
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            dcyc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (exp_addr != 64) addr_ok = 1'b0;
      @(negedge clk);
      if (busy || done) busy_ok = 1'b0;
   endtask

   typedef struct {
      string name;
      int    board_id;
      logic  color;
      int    exp_emits;
      int    exp_first_piece;
      int    exp_first_pos;
      int    exp_last_pos;
      int    exp_done_cyc;
   } scan_vec_t;

   scan_vec_t vecs [4];

   initial begin
      int  n, fp, fpos, lpos, dcyc, cyc, ev_cyc, pr_cyc;
      bit  addr_ok, emit_ok, busy_ok, seen, quiet;

      vecs[0] = '{"empty",      0, 1'b1, 0,  -1,        -1, -1, 129};
      vecs[1] = '{"open_white", 1, 1'b1, 16, 6'b110000, 0,  15, 177};
      vecs[2] = '{"open_black", 1, 1'b0, 16, 6'b000010, 48, 63, 177};
      vecs[3] = '{"mixed",      3, 1'b1, 2,  6'b100010, 5,  63, 135};

      reset = 1'b1; start = 1'b0; abort = 1'b0; engine_color = 1'b0; emit_ready = 1'b0;
      load_board(0);
      repeat (3) @(negedge clk);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_piece_reg", piece_reg, 0);
      chk("rst_pos_reg", pos_reg, 0);
      chk("rst_emit_valid", emit_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_piece_count", piece_count, 0);
      reset = 1'b0;
      @(negedge clk);

      // Table-driven full scans with the collector always ready.
      for (int v = 0; v < 4; v++) begin
         load_board(vecs[v].board_id);
         run_scan(vecs[v].color, n, fp, fpos, lpos, dcyc, addr_ok, emit_ok, busy_ok);
         chk({vecs[v].name, "_emits"}, n, vecs[v].exp_emits);
         chk({vecs[v].name, "_count"}, piece_count, vecs[v].exp_emits);
         chk({vecs[v].name, "_first_piece"}, fp, vecs[v].exp_first_piece);
         chk({vecs[v].name, "_first_pos"}, fpos, vecs[v].exp_first_pos);
         chk({vecs[v].name, "_last_pos"}, lpos, vecs[v].exp_last_pos);
         chk({vecs[v].name, "_done_cycle"}, dcyc, vecs[v].exp_done_cyc);
         chk({vecs[v].name, "_addr_order"}, addr_ok, 1);
         chk({vecs[v].name, "_emit_order_colour"}, emit_ok, 1);
         chk({vecs[v].name, "_busy_window"}, busy_ok, 1);
      end

      // Back-pressure on a lone black knight, with a stray start mid-scan.
      load_board(2);
      emit_ready = 1'b0;
      @(negedge clk); start = 1'b1; engine_color = 1'b0;
      @(negedge clk); start = 1'b0;
      cyc = 1; ev_cyc = -1; pr_cyc = -1;
      while (cyc < 200) begin
         if (pr_cyc < 0 && piece_reg != 6'b0) pr_cyc = cyc;
         if (emit_valid) begin
            ev_cyc = cyc;
            break;
         end
         if (cyc == 10) begin
            start = 1'b1; engine_color = 1'b1;
         end else begin
            start = 1'b0; engine_color = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; engine_color = 1'b0;
      chk("bp_piece_load_cycle", pr_cyc, 43);
      chk("bp_emit_valid_cycle", ev_cyc, 45);
      chk("bp_count_before", piece_count, 0);
      for (int k = 0; k < 5; k++) begin
         chk("bp_hold_valid", emit_valid, 1);
         chk("bp_hold_piece", piece_reg, 6'b000001);
         chk("bp_hold_pos", pos_reg, 20);
         @(negedge clk);
      end
      emit_ready = 1'b1;
      chk("bp_valid_at_ready", emit_valid, 1);
      @(negedge clk);
      emit_ready = 1'b0;
      chk("bp_valid_after_hs", emit_valid, 0);
      chk("bp_piece_after_hs", piece_reg, 0);
      chk("bp_count_after_hs", piece_count, 1);
      wait_sig(1, 300, seen);
      chk("bp_done_seen", seen, 1);
      chk("bp_final_count", piece_count, 1);
      @(negedge clk);

      // Abort in EMIT alongside emit_ready, then a clean rescan.
      load_board(4);
      emit_ready = 1'b0;
      @(negedge clk); start = 1'b1; engine_color = 1'b0;
      @(negedge clk); start = 1'b0;
      wait_sig(0, 300, seen);
      chk("ab_first_valid", seen, 1);
      emit_ready = 1'b1;
      @(negedge clk);
      emit_ready = 1'b0;
      wait_sig(0, 300, seen);
      chk("ab_second_valid", seen, 1);
      chk("ab_second_pos", pos_reg, 7);
      abort = 1'b1; emit_ready = 1'b1;
      @(negedge clk);
      abort = 1'b0; emit_ready = 1'b0;
      chk("ab_busy", busy, 0);
      chk("ab_emit_valid", emit_valid, 0);
      chk("ab_piece_reg", piece_reg, 0);
      chk("ab_pos_reg", pos_reg, 0);
      chk("ab_rd_en", rd_en, 0);
      chk("ab_count_kept", piece_count, 1);
      chk("ab_no_done", done, 0);
      quiet = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (done || busy || emit_valid) quiet = 1'b0;
      end
      chk("ab_stays_idle", quiet, 1);
      run_scan(1'b0, n, fp, fpos, lpos, dcyc, addr_ok, emit_ok, busy_ok);
      chk("rescan_addr_from_0", addr_ok, 1);
      chk("rescan_emits", n, 2);
      chk("rescan_first_pos", fpos, 3);
      chk("rescan_count", piece_count, 2);
      chk("rescan_done_cycle", dcyc, 135);

      // Reset mid-SETTLE, asserted together with start and abort.
      load_board(2);
      emit_ready = 1'b0;
      @(negedge clk); start = 1'b1; engine_color = 1'b0;
      @(negedge clk); start = 1'b0;
      wait_sig(2, 300, seen);
      chk("rs_reached_settle", seen, 1);
      chk("rs_not_yet_valid", emit_valid, 0);
      reset = 1'b1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      chk("rs_rd_en", rd_en, 0);
      chk("rs_rd_addr", rd_addr, 0);
      chk("rs_piece_reg", piece_reg, 0);
      chk("rs_pos_reg", pos_reg, 0);
      chk("rs_emit_valid", emit_valid, 0);
      chk("rs_busy", busy, 0);
      chk("rs_done", done, 0);
      chk("rs_piece_count", piece_count, 0);
      @(negedge clk);
      chk("rs_idle_after", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
